// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE754 single-precision subtractor (dataa - datab), truncating.
// Specials resolve at acceptance; finite operands go through ALIGN -> ADD -> NORM.
module fp_subtractor_seq #(
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    localparam logic [7:0] SPC8 = 8'(SHIFT_PER_CYCLE);
    localparam logic [8:0] SPC9 = 9'(SHIFT_PER_CYCLE);

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [31:0] result_q, result_d;
    logic [24:0] big_m_q, big_m_d;
    logic [23:0] small_m_q, small_m_d;
    logic [8:0]  exp_q, exp_d;
    logic [7:0]  diff_q, diff_d;
    logic        sign_q, sign_d, sub_q, sub_d;

    // Operand unpack; a zero exponent field behaves as exponent 1 without a hidden bit.
    logic        a_s, b_s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
    logic [7:0]  a_e, b_e, ea, eb, in_diff;
    logic [22:0] a_f, b_f;
    logic [23:0] ma, mb;
    logic        corner;
    logic [31:0] corner_res;

    always_comb begin
        {a_s, a_e, a_f} = dataa;
        {b_s, b_e, b_f} = datab;
        a_nan  = (a_e == 8'hFF) && (a_f != '0);
        b_nan  = (b_e == 8'hFF) && (b_f != '0);
        a_inf  = (a_e == 8'hFF) && (a_f == '0);
        b_inf  = (b_e == 8'hFF) && (b_f == '0);
        a_zero = (a_e == '0) && (a_f == '0);
        b_zero = (b_e == '0) && (b_f == '0);
        ea     = (a_e == '0) ? 8'd1 : a_e;
        eb     = (b_e == '0) ? 8'd1 : b_e;
        ma     = {|a_e, a_f};
        mb     = {|b_e, b_f};
        a_big  = (ea > eb) || ((ea == eb) && (ma >= mb));
        in_diff = a_big ? (ea - eb) : (eb - ea);

        corner     = 1'b1;
        corner_res = '0;
        if (a_nan)                          corner_res = dataa;
        else if (b_nan)                     corner_res = datab;
        else if (a_inf && b_inf && a_s == b_s) corner_res = 32'h7FC00000;
        else if (a_inf)                     corner_res = dataa;
        else if (b_inf)                     corner_res = {~b_s, datab[30:0]};
        else if (a_zero && b_zero)          corner_res = {a_s & ~b_s, 31'd0};
        else if (b_zero)                    corner_res = dataa;
        else if (a_zero)                    corner_res = {~b_s, datab[30:0]};
        else                                corner = 1'b0;
    end

    logic [4:0] lz;
    logic       lz_found;
    logic [7:0] align_sh;
    logic [8:0] norm_sh;

    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!lz_found) begin
                if (big_m_q[i]) lz_found = 1'b1;
                else            lz = lz + 5'd1;
            end
        end
        align_sh = (diff_q < SPC8) ? diff_q : SPC8;
        norm_sh  = SPC9;
        if ({4'd0, lz} < norm_sh)   norm_sh = {4'd0, lz};
        if ((exp_q - 9'd1) < norm_sh) norm_sh = exp_q - 9'd1;
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        big_m_d     = big_m_q;
        small_m_d   = small_m_q;
        exp_d       = exp_q;
        diff_d      = diff_q;
        sign_d      = sign_q;
        sub_d       = sub_q;
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                in_ready_d = 1'b0;
                if (corner) begin
                    result_d    = corner_res;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    // Effective sign of B is ~b_s, so the signs differ when a_s == b_s.
                    sub_d     = (a_s == b_s);
                    big_m_d   = {1'b0, a_big ? ma : mb};
                    small_m_d = a_big ? mb : ma;
                    exp_d     = {1'b0, a_big ? ea : eb};
                    sign_d    = a_big ? a_s : ~b_s;
                    diff_d    = in_diff;
                    state_d   = (in_diff == '0) ? ADD : ALIGN;
                end
            end
            ALIGN: begin
                if (diff_q >= 8'd25) begin
                    small_m_d = '0;
                    diff_d    = '0;
                    state_d   = ADD;
                end else begin
                    small_m_d = small_m_q >> align_sh;
                    diff_d    = diff_q - align_sh;
                    if (diff_q == align_sh) state_d = ADD;
                end
            end
            ADD: begin
                if (sub_q) begin
                    big_m_d = big_m_q - {1'b0, small_m_q};
                    if (big_m_q[23:0] == small_m_q) sign_d = 1'b0;
                end else begin
                    big_m_d = big_m_q + {1'b0, small_m_q};
                end
                state_d = NORM;
            end
            NORM: begin
                if (big_m_q[24]) begin
                    big_m_d = big_m_q >> 1;
                    exp_d   = exp_q + 9'd1;
                    if (exp_q == 9'd254) begin
                        result_d    = {sign_q, 8'hFF, 23'd0};
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end else if (!big_m_q[23] && (big_m_q != '0) && (exp_q > 9'd1)) begin
                    big_m_d = big_m_q << norm_sh;
                    exp_d   = exp_q - norm_sh;
                end else begin
                    result_d    = {sign_q, big_m_q[23] ? exp_q[7:0] : 8'd0, big_m_q[22:0]};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            big_m_q     <= '0;
            small_m_q   <= '0;
            exp_q       <= '0;
            diff_q      <= '0;
            sign_q      <= 1'b0;
            sub_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            big_m_q     <= big_m_d;
            small_m_q   <= small_m_d;
            exp_q       <= exp_d;
            diff_q      <= diff_d;
            sign_q      <= sign_d;
            sub_q       <= sub_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
endmodule
